// File: rtl/alu_sched_pkg.sv
// -----------------------------------------------------------------------------
// alu_sched_pkg
// Shared constants for the two-requester ALU scheduler:
//   - ALU function codes (add, sub, and, xor)
//   - condition-code bit positions inside cc_q
//   - scheduler FSM state encodings
//   - the latched operation record and a condition-code packing helper
// -----------------------------------------------------------------------------
package alu_sched_pkg;

   typedef enum logic [1:0] {
      FUN_ADD = 2'b00,
      FUN_SUB = 2'b01,
      FUN_AND = 2'b10,
      FUN_XOR = 2'b11
   } alu_fun_t;

   // Bit positions inside the 3-bit condition-code vector.
   localparam int CC_OF = 0;
   localparam int CC_SF = 1;
   localparam int CC_ZF = 2;

   // Condition codes after reset: only ZF set.
   localparam logic [2:0] CC_RESET = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // One in-flight operation, captured at the grant edge.
   typedef struct packed {
      alu_fun_t    fun;
      logic [63:0] a;
      logic [63:0] b;
      logic        setcc;   // only ever set for requester 0
      logic        owner;   // 0 = requester 0, 1 = requester 1
   } op_t;

   function automatic logic [2:0] pack_cc(input logic zf, input logic sf, input logic of);
      logic [2:0] cc;
      cc        = '0;
      cc[CC_ZF] = zf;
      cc[CC_SF] = sf;
      cc[CC_OF] = of;
      return cc;
   endfunction

endpackage

// File: rtl/alu_sched_alu.sv
// -----------------------------------------------------------------------------
// alu_sched_alu
// Purely combinational 64-bit ALU shared by both requesters.
// A single adder serves both add and subtract (subtract = a + ~b + 1).
// Ports:
//   alufun  in   2   function code (alu_fun_t encoding)
//   alua    in  64   first operand
//   alub    in  64   second operand
//   vale    out 64   result
//   cc      out  3   {ZF, SF, OF} computed from vale; OF only for add/sub
// -----------------------------------------------------------------------------
module alu_sched_alu
   import alu_sched_pkg::*;
(
   input  logic [1:0]  alufun,
   input  logic [63:0] alua,
   input  logic [63:0] alub,
   output logic [63:0] vale,
   output logic [2:0]  cc
);

   logic        is_sub;
   logic        is_arith;
   logic [63:0] addend;
   logic [63:0] sum;
   logic        of;

   assign is_sub   = (alufun == FUN_SUB);
   assign is_arith = (alufun == FUN_ADD) || (alufun == FUN_SUB);

   // Subtract reuses the adder: invert b and feed the +1 as carry-in.
   assign addend = alub ^ {64{is_sub}};
   assign sum    = alua + addend + {63'd0, is_sub};

   // Signed overflow: both adder inputs share a sign that the sum does not.
   assign of = is_arith && (alua[63] == addend[63]) && (sum[63] != alua[63]);

   // NOTE: every output of a combinational block gets a default before the
   // case so that no path leaves it unassigned and a latch is never inferred.
   always_comb begin
      vale = sum;
      case (alufun)
         FUN_AND: vale = alua & alub;
         FUN_XOR: vale = alua ^ alub;
         default: vale = sum;
      endcase
   end

   assign cc = pack_cc(vale == 64'd0, vale[63], of);

endmodule

// File: rtl/alu_sched.sv
// -----------------------------------------------------------------------------
// alu_sched
// Round-robin scheduler that lets two requesters (execute stage and address
// generation) share one ALU. An operation is latched in IDLE, evaluated in
// EXEC and reported with a one-cycle done pulse in DONE.
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous active-high reset
//   r0_req     in   1   requester 0 request, held until r0_done
//   r0_fun     in   2   requester 0 ALU function
//   r0_a/r0_b  in  64   requester 0 operands
//   r0_setcc   in   1   requester 0 result updates cc_q
//   r0_done    out  1   requester 0 result valid on res_valE (one cycle)
//   r1_req     in   1   requester 1 request, held until r1_done
//   r1_fun     in   2   requester 1 ALU function
//   r1_a/r1_b  in  64   requester 1 operands (never updates cc_q)
//   r1_done    out  1   requester 1 result valid on res_valE (one cycle)
//   res_valE   out 64   registered result of the last completed operation
//   cc_q       out  3   registered condition codes {ZF, SF, OF}
//   busy       out  1   high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module alu_sched
   import alu_sched_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        r0_req,
   input  logic [1:0]  r0_fun,
   input  logic [63:0] r0_a,
   input  logic [63:0] r0_b,
   input  logic        r0_setcc,
   output logic        r0_done,
   input  logic        r1_req,
   input  logic [1:0]  r1_fun,
   input  logic [63:0] r1_a,
   input  logic [63:0] r1_b,
   output logic        r1_done,
   output logic [63:0] res_valE,
   output logic [2:0]  cc_q,
   output logic        busy
);

   state_t      state;
   state_t      next_state;
   op_t         op;
   logic        last_grant;   // requester granted most recently
   logic        grant_sel;    // requester that wins this cycle
   logic        any_req;
   logic        latch_en;
   logic        exec_en;
   logic [63:0] alu_vale;
   logic [2:0]  alu_cc;

   // ---------------------------------------------------------------------
   // Round-robin arbiter: a lone request wins; on a tie the requester that
   // was not granted last wins.
   // ---------------------------------------------------------------------
   assign any_req = r0_req | r1_req;

   always_comb begin
      grant_sel = 1'b0;
      if (r0_req && r1_req) begin
         grant_sel = ~last_grant;
      end else if (r1_req) begin
         grant_sel = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments so all
   // registers update together at the edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
      next_state = state;
      latch_en   = 1'b0;
      exec_en    = 1'b0;
      r0_done    = 1'b0;
      r1_done    = 1'b0;
      busy       = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (any_req) begin
               latch_en   = 1'b1;
               next_state = ST_EXEC;
            end
         end
         ST_EXEC: begin
            exec_en    = 1'b1;
            next_state = ST_DONE;
         end
         ST_DONE: begin
            // A reset arriving in DONE aborts the report as well.
            r0_done    = ~op.owner & ~reset;
            r1_done    =  op.owner & ~reset;
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Last-granted tracker; after reset requester 0 wins the first tie.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
      end else if (latch_en) begin
         last_grant <= grant_sel;
      end
   end

   // ---------------------------------------------------------------------
   // Operand registers: captured only on the grant edge so later changes on
   // the request ports cannot disturb the operation in flight.
   // ---------------------------------------------------------------------
   // NOTE: pure datapath registers carry no reset; they are always written
   // before the FSM can read them, so clearing them would only add logic.
   always_ff @(posedge clk) begin
      if (latch_en) begin
         if (grant_sel) begin
            op <= '{fun: alu_fun_t'(r1_fun), a: r1_a, b: r1_b, setcc: 1'b0, owner: 1'b1};
         end else begin
            op <= '{fun: alu_fun_t'(r0_fun), a: r0_a, b: r0_b, setcc: r0_setcc, owner: 1'b0};
         end
      end
   end

   // ---------------------------------------------------------------------
   // The single ALU, fed only from the latched operands.
   // ---------------------------------------------------------------------
   alu_sched_alu u_alu (
      .alufun (op.fun),
      .alua   (op.a),
      .alub   (op.b),
      .vale   (alu_vale),
      .cc     (alu_cc)
   );

   // ---------------------------------------------------------------------
   // Result and condition-code registers, written at the EXEC edge. The
   // result then holds through DONE and IDLE until the next EXEC edge.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         res_valE <= '0;
         cc_q     <= CC_RESET;
      end else if (exec_en) begin
         res_valE <= alu_vale;
         if (!op.owner && op.setcc) begin
            cc_q <= alu_cc;
         end
      end
   end

endmodule
